// File: rtl/mux_stream_n.sv
// N-channel, W-bit streaming multiplexer with valid/ready handshakes and a
// one-deep registered output. Selection is fixed (sel) or round-robin (rr_en).
module mux_stream_n #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  input  logic [CHANNELS-1:0]         in_valid,
  output logic [CHANNELS-1:0]         in_ready,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        rr_en,
  output logic [WIDTH-1:0]            out_data,
  output logic [SEL_W-1:0]            out_sel,
  output logic                        out_valid,
  input  logic                        out_ready
);

  logic [WIDTH-1:0] ch_data [CHANNELS];
  logic             load;
  logic             grant_valid;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] ptr;
  int unsigned      idx;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_split
    assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
  end

  assign load = ~out_valid | out_ready;

  // Round-robin search starts at ptr and wraps modulo CHANNELS.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    if (!rr_en) begin
      if (32'(sel) < CHANNELS) begin
        grant       = sel;
        grant_valid = in_valid[sel];
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        idx = (32'(ptr) + i) % CHANNELS;
        if (!grant_valid && in_valid[SEL_W'(idx)]) begin
          grant_valid = 1'b1;
          grant       = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (!rst && load && grant_valid) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (grant_valid) begin
        out_data  <= ch_data[grant];
        out_sel   <= grant;
        out_valid <= 1'b1;
        if (32'(grant) == CHANNELS - 1) ptr <= '0;
        else                            ptr <= grant + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_stream_n.sv
// Bench for mux_stream_n: table of per-cycle stimulus with the expected grant,
// and a queue of expected output words compared when the consumer accepts.
module tb_mux_stream_n;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [2:0]  sel;
  logic        rr_en;
  logic [3:0]  out_data;
  logic [2:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  mux_stream_n #(.WIDTH(4), .CHANNELS(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .rr_en(rr_en), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] v;
    logic [2:0] s;
    logic       rr;
    logic       ordy;
    int         ch;    // expected granted channel, -1 for none
  } vec_t;

  vec_t       tbl[$];
  logic [6:0] q[$];    // expected {data, sel} words
  logic       ov_m;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] dat(input int k);
    logic [31:0] d;
    d = in_data;
    return d[k*4 +: 4];
  endfunction

  function automatic void add(input logic [7:0] v, input logic [2:0] s, input logic rr,
                              input logic ordy, input int ch);
    vec_t t;
    t.v = v; t.s = s; t.rr = rr; t.ordy = ordy; t.ch = ch;
    tbl.push_back(t);
  endfunction

  task automatic cyc(input vec_t t, input int n);
    logic [6:0] e;
    logic [7:0] er;
    in_valid  = t.v;
    sel       = t.s;
    rr_en     = t.rr;
    out_ready = t.ordy;
    #1;
    if (out_valid && out_ready) begin
      chk($sformatf("word_expected[%0d]", n), 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk($sformatf("out_data[%0d]", n), 32'(out_data), 32'(e[6:3]));
        chk($sformatf("out_sel[%0d]", n), 32'(out_sel), 32'(e[2:0]));
      end
    end else if (out_valid && q.size() != 0) begin
      chk($sformatf("stall_data[%0d]", n), 32'(out_data), 32'(q[0][6:3]));
      chk($sformatf("stall_sel[%0d]", n), 32'(out_sel), 32'(q[0][2:0]));
    end
    er = (t.ch >= 0) ? (8'd1 << t.ch) : 8'd0;
    chk($sformatf("in_ready[%0d]", n), 32'(in_ready), 32'(er));
    if (t.ch >= 0) begin
      q.push_back({dat(t.ch), 3'(t.ch)});
      ov_m = 1'b1;
    end else if (!ov_m || t.ordy) begin
      ov_m = 1'b0;
    end
    @(posedge clk);
    #1;
    chk($sformatf("out_valid[%0d]", n), 32'(out_valid), 32'(ov_m));
  endtask

  initial begin
    vec_t t;
    ov_m = 1'b0;
    for (int k = 0; k < 8; k++) in_data[k*4 +: 4] = 4'(k);

    // Reset with every channel requesting
    rst = 1'b1; in_valid = 8'hFF; rr_en = 1'b1; out_ready = 1'b1; sel = 3'd0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_sel", 32'(out_sel), 32'd0);
    end
    rst = 1'b0;

    add(8'hFF, 3'd0, 1'b1, 1'b1, 0);
    for (int k = 0; k < 8; k++) add(8'hFF, 3'(k), 1'b0, 1'b1, k);
    add(8'hFB, 3'd2, 1'b0, 1'b1, -1);
    add(8'hFB, 3'd7, 1'b0, 1'b1, 7);
    add(8'hA5, 3'd0, 1'b1, 1'b1, 0);
    add(8'hA5, 3'd0, 1'b1, 1'b1, 2);
    add(8'hA5, 3'd0, 1'b1, 1'b1, 5);
    add(8'hA5, 3'd0, 1'b1, 1'b1, 7);
    add(8'hA5, 3'd0, 1'b1, 1'b1, 0);
    add(8'hA5, 3'd0, 1'b1, 1'b1, 2);
    add(8'hA5, 3'd0, 1'b1, 1'b1, 5);
    for (int k = 0; k < 3; k++) add(8'hA5, 3'd0, 1'b1, 1'b0, -1);
    add(8'hA5, 3'd0, 1'b1, 1'b1, 7);
    add(8'hA5, 3'd0, 1'b1, 1'b1, 0);
    add(8'hFF, 3'd3, 1'b0, 1'b1, 3);
    add(8'hFF, 3'd3, 1'b0, 1'b1, 3);
    for (int k = 4; k < 9; k++) add(8'hFF, 3'd3, 1'b1, 1'b1, k % 8);
    add(8'h00, 3'd0, 1'b1, 1'b1, -1);

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], i);
    chk("drained_after_table", 32'(q.size()), 32'd0);

    // Reset while a word is held under back-pressure
    for (int k = 0; k < 8; k++) in_data[k*4 +: 4] = 4'(k*3 + 1);
    t.v = 8'hFF; t.s = 3'd0; t.rr = 1'b1; t.ordy = 1'b1; t.ch = 1;  cyc(t, 100);
    t.ordy = 1'b0; t.ch = -1;                                        cyc(t, 101);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_sel", 32'(out_sel), 32'd0);
    rst = 1'b0;
    q.delete();
    ov_m = 1'b0;
    t.ordy = 1'b0; t.ch = 0;              cyc(t, 102);
    t.ordy = 1'b1; t.ch = 1;              cyc(t, 103);
    t.v = 8'h00; t.ch = -1;               cyc(t, 104);
    chk("drained_final", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
